maze_mem_arbiter: RTL and testbench

Shares the single-port 16x16 maze bit-memory between two requesters: the solver datapath (wall/visited reads, visited-mark writes) and a host loader (maze download and debug readback). It performs fair two-way round-robin arbitration and blocks host writes while the solver is running. It also contains a clear sequencer that sweeps every cell to 0 before a new solve. The block sits between the datapath's memory port and the memory macro.

---
 rtl/maze_pkg.sv | 17 +
 rtl/rr_arb2.sv | 35 +++
 rtl/maze_mem_arbiter.sv | 133 +++++++++++++
 tb/tb_maze_mem_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// maze_pkg: shared widths, FSM encoding and requester IDs for the maze
// memory arbiter and its round-robin sub-block.
package maze_pkg;

    // Default geometry: 16x16 cells, address is {y, x}.
    localparam int MAZE_DIM_W  = 4;
    localparam int MAZE_ADDR_W = 2 * MAZE_DIM_W;

    // FSM encoding (plain constants so older tools can share them).
    localparam logic [0:0] ST_ARB   = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    // Requester IDs, also used as bit positions in the grant vector.
    localparam logic REQ_SOLVER = 1'b0;
    localparam logic REQ_HOST   = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin arbiter. On a tie the requester that did
// not win last time is granted. The history only advances when the
// grant is actually accepted, so a suppressed cycle does not skew fairness.
module rr_arb2
    import maze_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    logic last_winner;

    // Pick the single requester, or on a tie the one that lost last time.
    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = (last_winner == REQ_HOST) ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
    end

    // Remember who won; the host starts as last winner so the solver wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_winner <= REQ_HOST;
        end else if (accept && (gnt != 2'b00)) begin
            last_winner <= gnt[REQ_HOST] ? REQ_HOST : REQ_SOLVER;
        end
    end

endmodule

// File: rtl/maze_mem_arbiter.sv
// maze_mem_arbiter: shares the single-port maze bit-memory between the
// solver datapath and the host loader, blocks host writes while a solve is
// running, and owns the clear sweep that zeroes every cell before a solve.
module maze_mem_arbiter
    import maze_pkg::*;
#(
    parameter int DIM_W  = MAZE_DIM_W,
    parameter int ADDR_W = MAZE_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              s_req,
    input  logic              s_we,
    input  logic [DIM_W-1:0]  s_x,
    input  logic [DIM_W-1:0]  s_y,
    input  logic              s_din,
    output logic              s_gnt,
    output logic              s_rvalid,
    output logic              s_dout,

    input  logic              h_req,
    input  logic              h_we,
    input  logic [DIM_W-1:0]  h_x,
    input  logic [DIM_W-1:0]  h_y,
    input  logic              h_din,
    output logic              h_gnt,
    output logic              h_err,
    output logic              h_rvalid,
    output logic              h_dout,

    input  logic              solver_busy,
    input  logic              clr_req,
    output logic              clr_done,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_din,
    input  logic              mem_dout
);

    // One extra counter bit keeps the terminal compare free of wrap-around.
    localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'((1 << ADDR_W) - 1);
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

    logic [0:0]      state;
    logic [ADDR_W:0] clr_cnt;
    logic            clr_last;
    logic            arb_accept;
    logic [1:0]      arb_req;
    logic [1:0]      arb_gnt;
    logic            h_blocked;

    assign arb_req    = {h_req, s_req};
    assign arb_accept = (state == ST_ARB) && !clr_req;
    assign clr_last   = (clr_cnt == CNT_LAST);

    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .rst    (rst),
        .req    (arb_req),
        .accept (arb_accept),
        .gnt    (arb_gnt)
    );

    // A grant only stands while arbitrating and no clear is being requested.
    assign s_gnt     = arb_accept && arb_gnt[REQ_SOLVER];
    assign h_gnt     = arb_accept && arb_gnt[REQ_HOST];
    assign h_blocked = h_gnt && h_we && solver_busy;
    assign h_err     = h_blocked;

    // Drive the memory port from the sweep, the granted requester, or nothing.
    always_comb begin
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_din  = 1'b0;
        if (state == ST_CLEAR) begin
            mem_en   = 1'b1;
            mem_we   = 1'b1;
            mem_addr = clr_cnt[ADDR_W-1:0];
        end else if (s_gnt) begin
            mem_en   = 1'b1;
            mem_we   = s_we;
            mem_addr = {s_y, s_x};
            mem_din  = s_we & s_din;
        end else if (h_gnt && !h_blocked) begin
            mem_en   = 1'b1;
            mem_we   = h_we;
            mem_addr = {h_y, h_x};
            mem_din  = h_we & h_din;
        end
    end

    // Sequence ARB/CLEAR and step the sweep address; flag the end one cycle late.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_ARB;
            clr_cnt  <= '0;
            clr_done <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            if (state == ST_ARB) begin
                if (clr_req) begin
                    state   <= ST_CLEAR;
                    clr_cnt <= '0;
                end
            end else begin
                clr_cnt <= clr_cnt + CNT_ONE;
                if (clr_last) begin
                    state    <= ST_ARB;
                    clr_done <= 1'b1;
                end
            end
        end
    end

    // Remember which requester issued a read so the returning bit goes back to it.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_rvalid <= 1'b0;
            h_rvalid <= 1'b0;
        end else begin
            s_rvalid <= s_gnt && !s_we;
            h_rvalid <= h_gnt && !h_we;
        end
    end

    assign s_dout = s_rvalid & mem_dout;
    assign h_dout = h_rvalid & mem_dout;

endmodule

// File: tb/tb_maze_mem_arbiter.sv
// tb_maze_mem_arbiter: directed vector table plus hand-written sequences for
// the clear sweep, reset during a sweep and sustained round-robin.
module tb_maze_mem_arbiter;

    logic       clk;
    logic       rst;
    logic       s_req, s_we, s_din;
    logic [3:0] s_x, s_y;
    logic       s_gnt, s_rvalid, s_dout;
    logic       h_req, h_we, h_din;
    logic [3:0] h_x, h_y;
    logic       h_gnt, h_err, h_rvalid, h_dout;
    logic       solver_busy, clr_req, clr_done;
    logic       mem_en, mem_we, mem_din, mem_dout;
    logic [7:0] mem_addr;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       sreq, swe;
        logic [3:0] sx, sy;
        logic       sdin;
        logic       hreq, hwe;
        logic [3:0] hx, hy;
        logic       hdin;
        logic       busy;
        logic       e_sgnt, e_hgnt, e_herr, e_srv, e_sdo, e_hrv, e_hdo;
        logic       e_en, e_we;
        logic [7:0] e_addr;
        logic       e_din;
    } vec_t;

    vec_t vecs[15];

    maze_mem_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .s_req       (s_req),
        .s_we        (s_we),
        .s_x         (s_x),
        .s_y         (s_y),
        .s_din       (s_din),
        .s_gnt       (s_gnt),
        .s_rvalid    (s_rvalid),
        .s_dout      (s_dout),
        .h_req       (h_req),
        .h_we        (h_we),
        .h_x         (h_x),
        .h_y         (h_y),
        .h_din       (h_din),
        .h_gnt       (h_gnt),
        .h_err       (h_err),
        .h_rvalid    (h_rvalid),
        .h_dout      (h_dout),
        .solver_busy (solver_busy),
        .clr_req     (clr_req),
        .clr_done    (clr_done),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_din     (mem_din),
        .mem_dout    (mem_dout)
    );

    // Free-running clock, rising edge active.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural single-port memory macro with a registered read port.
    logic mem_model [256];
    initial begin
        for (int i = 0; i < 256; i++) mem_model[i] = 1'b0;
        mem_dout = 1'b0;
    end
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem_model[mem_addr] <= mem_din;
            else        mem_dout <= mem_model[mem_addr];
        end
    end

    // Safety net in case the DUT stalls a sequence forever.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    function automatic vec_t mk(
        input logic sreq, swe, input logic [3:0] sx, sy, input logic sdin,
        input logic hreq, hwe, input logic [3:0] hx, hy, input logic hdin,
        input logic busy,
        input logic sg, hg, herr, srv, sdo, hrv, hdo, en, we,
        input logic [7:0] addr, input logic din);
        vec_t v;
        v.sreq = sreq; v.swe = swe; v.sx = sx; v.sy = sy; v.sdin = sdin;
        v.hreq = hreq; v.hwe = hwe; v.hx = hx; v.hy = hy; v.hdin = hdin;
        v.busy = busy;
        v.e_sgnt = sg; v.e_hgnt = hg; v.e_herr = herr;
        v.e_srv = srv; v.e_sdo = sdo; v.e_hrv = hrv; v.e_hdo = hdo;
        v.e_en = en; v.e_we = we; v.e_addr = addr; v.e_din = din;
        return v;
    endfunction

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        s_req = 0; s_we = 0; s_x = 0; s_y = 0; s_din = 0;
        h_req = 0; h_we = 0; h_x = 0; h_y = 0; h_din = 0;
        solver_busy = 0;
    endtask

    task automatic applyStimulus(input vec_t v);
        s_req = v.sreq; s_we = v.swe; s_x = v.sx; s_y = v.sy; s_din = v.sdin;
        h_req = v.hreq; h_we = v.hwe; h_x = v.hx; h_y = v.hy; h_din = v.hdin;
        solver_busy = v.busy;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic readCell(input logic from_host, input logic [3:0] x, y,
                            input logic exp_d, input string name);
        if (from_host) begin
            h_req = 1; h_we = 0; h_x = x; h_y = y;
        end else begin
            s_req = 1; s_we = 0; s_x = x; s_y = y;
        end
        @(negedge clk);
        checkOutput({name, "_gnt"}, from_host ? h_gnt : s_gnt, 1);
        stepCycle();
        s_req = 0; h_req = 0;
        @(negedge clk);
        checkOutput({name, "_rvalid"}, from_host ? h_rvalid : s_rvalid, 1);
        checkOutput({name, "_dout"}, from_host ? h_dout : s_dout, exp_d);
        stepCycle();
    endtask

    task automatic hostWrite(input logic [3:0] x, y, input logic d, input string name);
        h_req = 1; h_we = 1; h_x = x; h_y = y; h_din = d;
        @(negedge clk);
        checkOutput({name, "_gnt"}, h_gnt, 1);
        checkOutput({name, "_we"}, mem_we, 1);
        stepCycle();
        h_req = 0; h_we = 0;
    endtask

    initial begin : main
        int sweep_bad;
        int first_bad;
        int stray;
        int cnt;
        logic done_seen;
        int ns, nh;

        rst = 1; clr_req = 0;
        idleInputs();

        // Reset state
        repeat (2) stepCycle();
        @(negedge clk);
        checkOutput("rst_s_gnt", s_gnt, 0);
        checkOutput("rst_mem_en", mem_en, 0);
        checkOutput("rst_clr_done", clr_done, 0);
        stepCycle();
        rst = 0;
        @(negedge clk);
        checkOutput("post_rst_s_rvalid", s_rvalid, 0);
        checkOutput("post_rst_h_rvalid", h_rvalid, 0);
        checkOutput("post_rst_mem_addr", mem_addr, 0);
        stepCycle();

        // Directed table: tie order, read return, host write, write block, ties after history
        vecs[0]  = mk(1,0,2,3,0,   1,0,5,5,0,    0, 1,0,0,0,0,0,0, 1,0,8'h32,0);
        vecs[1]  = mk(0,0,0,0,0,   1,0,5,5,0,    0, 0,1,0,1,0,0,0, 1,0,8'h55,0);
        vecs[2]  = mk(0,0,0,0,0,   0,0,0,0,0,    0, 0,0,0,0,0,1,0, 0,0,8'h00,0);
        vecs[3]  = mk(0,0,0,0,0,   1,1,15,15,1,  0, 0,1,0,0,0,0,0, 1,1,8'hFF,1);
        vecs[4]  = mk(1,0,15,15,0, 0,0,0,0,0,    0, 1,0,0,0,0,0,0, 1,0,8'hFF,0);
        vecs[5]  = mk(0,0,0,0,0,   0,0,0,0,0,    0, 0,0,0,1,1,0,0, 0,0,8'h00,0);
        vecs[6]  = mk(0,0,0,0,0,   1,1,0,0,1,    1, 0,1,1,0,0,0,0, 0,0,8'h00,0);
        vecs[7]  = mk(1,0,0,0,0,   0,0,0,0,0,    1, 1,0,0,0,0,0,0, 1,0,8'h00,0);
        vecs[8]  = mk(0,0,0,0,0,   0,0,0,0,0,    1, 0,0,0,1,0,0,0, 0,0,8'h00,0);
        vecs[9]  = mk(0,0,0,0,0,   1,0,0,0,0,    1, 0,1,0,0,0,0,0, 1,0,8'h00,0);
        vecs[10] = mk(0,0,0,0,0,   0,0,0,0,0,    0, 0,0,0,0,0,1,0, 0,0,8'h00,0);
        vecs[11] = mk(1,1,7,4,1,   0,0,0,0,0,    0, 1,0,0,0,0,0,0, 1,1,8'h47,1);
        vecs[12] = mk(1,0,7,4,0,   1,0,1,2,0,    0, 0,1,0,0,0,0,0, 1,0,8'h21,0);
        vecs[13] = mk(1,0,7,4,0,   0,0,0,0,0,    0, 1,0,0,0,0,1,0, 1,0,8'h47,0);
        vecs[14] = mk(0,0,0,0,0,   0,0,0,0,0,    0, 0,0,0,1,1,0,0, 0,0,8'h00,0);

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput($sformatf("v%0d_s_gnt", i),    s_gnt,    vecs[i].e_sgnt);
            checkOutput($sformatf("v%0d_h_gnt", i),    h_gnt,    vecs[i].e_hgnt);
            checkOutput($sformatf("v%0d_h_err", i),    h_err,    vecs[i].e_herr);
            checkOutput($sformatf("v%0d_s_rvalid", i), s_rvalid, vecs[i].e_srv);
            checkOutput($sformatf("v%0d_s_dout", i),   s_dout,   vecs[i].e_sdo);
            checkOutput($sformatf("v%0d_h_rvalid", i), h_rvalid, vecs[i].e_hrv);
            checkOutput($sformatf("v%0d_h_dout", i),   h_dout,   vecs[i].e_hdo);
            checkOutput($sformatf("v%0d_mem_en", i),   mem_en,   vecs[i].e_en);
            checkOutput($sformatf("v%0d_mem_we", i),   mem_we,   vecs[i].e_we);
            checkOutput($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].e_addr);
            checkOutput($sformatf("v%0d_mem_din", i),  mem_din,  vecs[i].e_din);
            stepCycle();
        end
        idleInputs();

        // Preload a few more cells and confirm they hold 1
        hostWrite(4'd0, 4'd0, 1'b1, "preload_00");
        hostWrite(4'd0, 4'd8, 1'b1, "preload_80");
        readCell(1'b0, 4'd0, 4'd8, 1'b1, "pre_rd_80");
        readCell(1'b1, 4'd0, 4'd0, 1'b1, "pre_rd_00");

        // Clear sweep with the solver requesting throughout
        s_req = 1; s_we = 0; s_x = 3; s_y = 3; clr_req = 1;
        @(negedge clk);
        checkOutput("clr_req_s_gnt", s_gnt, 0);
        checkOutput("clr_req_mem_en", mem_en, 0);
        stepCycle();
        clr_req = 0;
        sweep_bad = 0;
        first_bad = -1;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (!(mem_en === 1'b1 && mem_we === 1'b1 && mem_din === 1'b0 &&
                  mem_addr === 8'(i) && s_gnt === 1'b0 && h_gnt === 1'b0 &&
                  clr_done === 1'b0)) begin
                sweep_bad++;
                if (first_bad < 0) first_bad = i;
            end
            stepCycle();
        end
        if (sweep_bad != 0) $display("[TB] first bad sweep cycle %0d", first_bad);
        checkOutput("sweep_bad_cycles", sweep_bad, 0);
        @(negedge clk);
        checkOutput("clr_done_pulse", clr_done, 1);
        checkOutput("clr_done_cycle_s_gnt", s_gnt, 1);
        checkOutput("clr_done_cycle_addr", mem_addr, 8'h33);
        checkOutput("clr_done_cycle_we", mem_we, 0);
        stepCycle();
        s_req = 0;
        @(negedge clk);
        checkOutput("clr_done_single", clr_done, 0);
        checkOutput("post_clr_s_rvalid", s_rvalid, 1);
        checkOutput("post_clr_s_dout", s_dout, 0);
        stepCycle();
        readCell(1'b1, 4'd15, 4'd15, 1'b0, "clr_rd_ff");
        readCell(1'b1, 4'd7,  4'd4,  1'b0, "clr_rd_47");
        readCell(1'b1, 4'd0,  4'd0,  1'b0, "clr_rd_00");
        readCell(1'b1, 4'd0,  4'd8,  1'b0, "clr_rd_80");

        // Reset in the middle of a sweep, then a fresh sweep from address 0
        clr_req = 1;
        stepCycle();
        clr_req = 0;
        repeat (100) stepCycle();
        @(negedge clk);
        checkOutput("abort_addr_100", mem_addr, 8'd100);
        rst = 1;
        stepCycle();
        @(negedge clk);
        checkOutput("abort_mem_en", mem_en, 0);
        checkOutput("abort_mem_we", mem_we, 0);
        checkOutput("abort_mem_addr", mem_addr, 0);
        checkOutput("abort_clr_done", clr_done, 0);
        rst = 0;
        stepCycle();
        stray = 0;
        repeat (300) begin
            @(negedge clk);
            if (clr_done !== 1'b0 || mem_en !== 1'b0) stray++;
            stepCycle();
        end
        checkOutput("abort_quiet_cycles", stray, 0);
        clr_req = 1;
        stepCycle();
        clr_req = 0;
        @(negedge clk);
        checkOutput("restart_addr0", mem_addr, 0);
        checkOutput("restart_we", mem_we, 1);
        cnt = 0;
        done_seen = 0;
        while (cnt < 300 && !done_seen) begin
            stepCycle();
            @(negedge clk);
            cnt++;
            if (clr_done === 1'b1) done_seen = 1;
        end
        checkOutput("restart_done_seen", done_seen, 1);
        checkOutput("restart_sweep_len", cnt, 256);
        stepCycle();

        // Sustained contention: grants must alternate starting with the solver
        rst = 1;
        stepCycle();
        rst = 0;
        s_req = 1; s_we = 0; s_x = 1; s_y = 1;
        h_req = 1; h_we = 0; h_x = 2; h_y = 2;
        ns = 0;
        nh = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput($sformatf("rr_%0d_s_gnt", i), s_gnt, (i % 2) == 0);
            checkOutput($sformatf("rr_%0d_h_gnt", i), h_gnt, (i % 2) != 0);
            if (s_gnt === 1'b1) ns++;
            if (h_gnt === 1'b1) nh++;
            stepCycle();
        end
        idleInputs();
        checkOutput("rr_solver_grants", ns, 5);
        checkOutput("rr_host_grants", nh, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
